// File: rtl/rr_arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
// Imported by the pick logic and the arbiter top.
package rr_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick_8.sv
// Rotate-and-priority search: first set req bit at or after ptr.
// Purely combinational; any flags a non-empty request vector.
module rr_pick_8
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   w,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SEL_W-1:0]     off;

    // Bit k of rot is requester ptr+k, so the lowest set bit wins.
    assign dbl = {req, req};
    assign rot = dbl[ptr +: NUM_REQ];

    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
    end

    assign w   = ptr + off;
    assign any = |req;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter driving a 3-to-8 decoder (sel -> S, en -> E).
// Grants end on req drop or hold timeout, always followed by one idle cycle.
module rr_arbiter_8
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [SEL_W-1:0]   sel,
    output logic               en,
    output logic               timeout
);

    localparam logic [CNT_W-1:0] LAST =
        CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] w;
    logic             any;
    logic             hit;
    logic             held;

    rr_pick_8 u_pick (
        .req (req),
        .ptr (ptr),
        .w   (w),
        .any (any)
    );

    assign held = req[sel];
    assign hit  = (MAX_HOLD != 0) && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel     <= '0;
            en      <= 1'b0;
            timeout <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        sel   <= w;
                        en    <= 1'b1;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!held || hit) begin
                        en      <= 1'b0;
                        ptr     <= sel + SEL_W'(1);
                        state   <= IDLE;
                        // A holder that dropped req is a normal release.
                        timeout <= held;
                    end else if (MAX_HOLD != 0) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: vector table plus
// hand-built rotation, timeout and reset sequences.
module tb_rr_arbiter_8;

    typedef struct packed {
        logic [7:0] req;
        logic       en;
        logic [2:0] sel;
        logic       to;
    } vec_t;

    typedef struct packed {
        logic       en;
        logic [2:0] sel;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [2:0] sel;
    logic       en;
    logic       timeout;
    logic [7:0] req1;
    logic [2:0] sel1;
    logic       en1;
    logic       timeout1;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    vec_t tbl[16];

    always #5 clk = ~clk;

    rr_arbiter_8 #(.MAX_HOLD(16), .CNT_W(5)) u0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .sel     (sel),
        .en      (en),
        .timeout (timeout)
    );

    rr_arbiter_8 #(.MAX_HOLD(0), .CNT_W(5)) u1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req1),
        .sel     (sel1),
        .en      (en1),
        .timeout (timeout1)
    );

    task automatic chk(input string nm,
                       input logic [4:0] act,
                       input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: en/sel/to got %b expected %b",
                     nm, act, exp);
        end
    endtask

    // Drive req, queue expected outputs, sample #1 after the edge.
    task automatic step(input logic [7:0] r, input logic e,
                        input logic [2:0] s, input logic t,
                        input string nm);
        exp_t x;
        req = r;
        sbq.push_back('{en: e, sel: s, to: t});
        @(posedge clk);
        #1;
        x = sbq.pop_front();
        chk(nm, {en, sel, timeout}, x);
    endtask

    task automatic do_reset();
        req   = 8'h00;
        req1  = 8'h00;
        rst_n = 1'b0;
        #1;
        chk("reset_u0", {en, sel, timeout}, 5'b0);
        chk("reset_u1", {en1, sel1, timeout1}, 5'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] r;
        logic [2:0] wv;

        tbl[0]  = '{8'h00, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{8'h04, 1'b1, 3'd2, 1'b0};
        tbl[2]  = '{8'h04, 1'b1, 3'd2, 1'b0};
        tbl[3]  = '{8'h00, 1'b0, 3'd2, 1'b0};
        tbl[4]  = '{8'h00, 1'b0, 3'd2, 1'b0};
        tbl[5]  = '{8'h81, 1'b1, 3'd7, 1'b0};
        tbl[6]  = '{8'h00, 1'b0, 3'd7, 1'b0};
        tbl[7]  = '{8'h81, 1'b1, 3'd0, 1'b0};
        tbl[8]  = '{8'h80, 1'b0, 3'd0, 1'b0};
        tbl[9]  = '{8'h80, 1'b1, 3'd7, 1'b0};
        tbl[10] = '{8'h81, 1'b1, 3'd7, 1'b0};
        tbl[11] = '{8'h01, 1'b0, 3'd7, 1'b0};
        tbl[12] = '{8'h01, 1'b1, 3'd0, 1'b0};
        tbl[13] = '{8'h00, 1'b0, 3'd0, 1'b0};
        tbl[14] = '{8'h06, 1'b1, 3'd1, 1'b0};
        tbl[15] = '{8'h00, 1'b0, 3'd1, 1'b0};

        rst_n = 1'b0;
        req   = 8'h00;
        req1  = 8'h00;
        #2;
        do_reset();

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].req, tbl[i].en, tbl[i].sel,
                 tbl[i].to, $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of a grant.
        do_reset();
        step(8'h04, 1'b1, 3'd2, 1'b0, "pre_async");
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {en, sel, timeout}, 5'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(8'h04, 1'b1, 3'd2, 1'b0, "post_async");

        // Rotation: everyone requests, each holder drops after 2.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            wv = 3'(k % 8);
            r  = 8'hFF;
            step(r, 1'b1, wv, 1'b0, $sformatf("rot%0d_a", k));
            step(r, 1'b1, wv, 1'b0, $sformatf("rot%0d_b", k));
            r[wv] = 1'b0;
            step(r, 1'b0, wv, 1'b0, $sformatf("rot%0d_gap", k));
        end

        // Single requester held forever: 16-cycle grants.
        do_reset();
        for (int g = 0; g < 2; g++) begin
            for (int c = 0; c < 16; c++) begin
                step(8'h08, 1'b1, 3'd3, 1'b0,
                     $sformatf("hold%0d_%0d", g, c));
            end
            step(8'h08, 1'b0, 3'd3, 1'b1,
                 $sformatf("hold%0d_to", g));
        end

        // Two requesters held: alternate with a pulse each time.
        do_reset();
        for (int g = 0; g < 4; g++) begin
            wv = (g % 2 == 0) ? 3'd0 : 3'd3;
            for (int c = 0; c < 16; c++) begin
                step(8'h09, 1'b1, wv, 1'b0,
                     $sformatf("fair%0d_%0d", g, c));
            end
            step(8'h09, 1'b0, wv, 1'b1,
                 $sformatf("fair%0d_to", g));
        end

        // Drop on the very cycle the timeout would fire.
        do_reset();
        for (int c = 0; c < 16; c++) begin
            step(8'h08, 1'b1, 3'd3, 1'b0,
                 $sformatf("simul_%0d", c));
        end
        step(8'h00, 1'b0, 3'd3, 1'b0, "simul_drop");
        step(8'h00, 1'b0, 3'd3, 1'b0, "simul_idle");

        // MAX_HOLD=0: a 100-cycle hold never times out.
        do_reset();
        req1 = 8'h20;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("nohold_%0d", c),
                {en1, sel1, timeout1}, {1'b1, 3'd5, 1'b0});
        end
        req1 = 8'h00;
        @(posedge clk);
        #1;
        chk("nohold_rel", {en1, sel1, timeout1},
            {1'b0, 3'd5, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
